dt_result_packer: RTL and testbench

- Reads back the 128x128 8-bit distance map from the result RAM once the distance-transform pass has finished.
- Compares every pixel against a threshold and packs the 1-bit results into 16-bit words, in the same layout as the binary source image: 1024 words, pixel 16*w+k in bit (15-k) of word w.
- Streams the words out over a valid/ready interface, with the word index, for write-back to image storage or for host readout.

---
 rtl/dt_result_packer.sv | 129 ++++++++++++
 tb/tb_dt_result_packer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dt_result_packer.sv
// Threshold-and-pack readback of the 128x128 distance map into 1024 16-bit words, MSB-first.
// Optional running maximum of the map is built when DT_PACKER_MAX_EN is defined.
module dt_result_packer #(
    parameter int IMG_W  = 128,
    parameter int WORD_W = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [7:0]  thr_i,
    output logic        res_rd_o,
    output logic [13:0] res_addr_o,
    input  logic [7:0]  res_di_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [15:0] out_data_o,
    output logic [9:0]  out_addr_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [7:0]  max_dist_o
);

    // state | meaning
    // IDLE  | waiting for start
    // READ  | 16 reads, one pixel per cycle, shifted into the word
    // OUT   | completed word offered downstream
    // FIN   | last word accepted; done follows next cycle
    typedef enum logic [1:0] {IDLE, READ, OUT, FIN} state_t;

    localparam logic [9:0] LAST_WORD = 10'(IMG_W * IMG_W / WORD_W - 1);
    localparam logic [3:0] LAST_SLOT = 4'(WORD_W - 1);

    state_t      state_q, state_d;
    logic [13:0] pix_q, pix_d;
    logic [15:0] shift_q, shift_d;
    logic [7:0]  thr_q, thr_d;
    logic [15:0] data_q, data_d;
    logic [9:0]  addr_q, addr_d;
    logic        done_q, done_d;
    logic        pix_bit;

    assign pix_bit = (res_di_i >= thr_q);

    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        shift_d = shift_q;
        thr_d   = thr_q;
        data_d  = data_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    thr_d   = thr_i;
                    pix_d   = '0;
                    shift_d = '0;
                    state_d = READ;
                end
            end
            READ: begin
                shift_d = {shift_q[14:0], pix_bit};
                pix_d   = pix_q + 14'd1;
                if (pix_q[3:0] == LAST_SLOT) begin
                    data_d  = {shift_q[14:0], pix_bit};
                    addr_d  = pix_q[13:4];
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_ready_i) begin
                    state_d = (addr_q == LAST_WORD) ? FIN : READ;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            pix_q   <= '0;
            shift_q <= '0;
            thr_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            shift_q <= shift_d;
            thr_q   <= thr_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
        end
    end

    assign res_rd_o    = (state_q == READ);
    assign res_addr_o  = (state_q == READ) ? pix_q : 14'd0;
    assign out_valid_o = (state_q == OUT);
    assign out_data_o  = data_q;
    assign out_addr_o  = addr_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;

`ifdef DT_PACKER_MAX_EN
    logic [7:0] max_q;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            max_q <= '0;
        end else if (state_q == IDLE && start_i) begin
            max_q <= '0;
        end else if (state_q == READ && res_di_i > max_q) begin
            max_q <= res_di_i;
        end
    end

    assign max_dist_o = max_q;
`else
    assign max_dist_o = 8'd0;
`endif

endmodule

// File: tb/tb_dt_result_packer.sv
// Directed self-checking bench for dt_result_packer: reset abort, full passes, back-pressure, ignored restart.
module tb_dt_result_packer;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        start_i;
    logic [7:0]  thr_i;
    logic        res_rd_o;
    logic [13:0] res_addr_o;
    logic [7:0]  res_di_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] out_data_o;
    logic [9:0]  out_addr_o;
    logic        busy_o;
    logic        done_o;
    logic [7:0]  max_dist_o;

    logic [7:0] ram [0:16383];
    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

`ifdef DT_PACKER_MAX_EN
    localparam logic [7:0] RAMP_MAX = 8'd255;
    localparam logic [7:0] ONE_MAX  = 8'd5;
`else
    localparam logic [7:0] RAMP_MAX = 8'd0;
    localparam logic [7:0] ONE_MAX  = 8'd0;
`endif

    dt_result_packer dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .thr_i       (thr_i),
        .res_rd_o    (res_rd_o),
        .res_addr_o  (res_addr_o),
        .res_di_i    (res_di_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_addr_o  (out_addr_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .max_dist_o  (max_dist_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    assign res_di_i = ram[res_addr_o];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference packing straight from the bench RAM image.
    function automatic logic [15:0] ref_word(input int w, input logic [7:0] t);
        logic [15:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) r[15-k] = (ram[16*w+k] >= t);
        return r;
    endfunction

    task automatic do_pass(input logic [7:0] t, input bit stall, input bit restart,
                           input bit chk_done, input logic [7:0] exp_max);
        int s0;
        int wait_n;
        out_ready_i = !stall;
        start_i = 1'b1;
        thr_i   = t;
        s0      = cyc;
        @(negedge clk_i);
        start_i = 1'b0;
        thr_i   = ~t;
        chk("busy_after_start", busy_o, 1);
        for (int w = 0; w < 1024; w++) begin
            wait_n = 0;
            while (!out_valid_o && wait_n < 40) begin
                chk("res_rd_in_read", res_rd_o, 1);
                chk("res_addr", res_addr_o, 16*w + wait_n);
                @(negedge clk_i);
                wait_n++;
            end
            if (!out_valid_o) begin
                chk("wait_valid", out_valid_o, 1);
                return;
            end
            if (w == 0) chk("first_valid_cycle", cyc - s0, 17);
            chk("out_addr", out_addr_o, w);
            chk("out_data", out_data_o, ref_word(w, t));
            chk("res_rd_low_in_out", res_rd_o, 0);
            chk("res_addr_zero_in_out", res_addr_o, 0);
            if (restart && w == 100) begin
                start_i = 1'b1;
                thr_i   = 8'h00;
            end
            if (stall && w == 0) begin
                for (int i = 0; i < 50; i++) begin
                    chk("stall_valid", out_valid_o, 1);
                    chk("stall_data", out_data_o, 16'h00FF);
                    chk("stall_addr", out_addr_o, 0);
                    chk("stall_res_rd", res_rd_o, 0);
                    if (i < 49) @(negedge clk_i);
                end
                out_ready_i = 1'b1;
            end
            @(negedge clk_i);
            start_i = 1'b0;
            chk("valid_drop", out_valid_o, 0);
        end
        chk("fin_busy", busy_o, 1);
        chk("fin_no_done_yet", done_o, 0);
        @(negedge clk_i);
        chk("done_pulse", done_o, 1);
        chk("busy_low_at_done", busy_o, 0);
        if (chk_done) chk("done_cycle", cyc - s0, 17410);
        chk("max_dist", max_dist_o, exp_max);
        @(negedge clk_i);
        chk("done_single", done_o, 0);
        chk("max_dist_hold", max_dist_o, exp_max);
    endtask

    initial begin
        int wait_n;
        reset_i     = 1'b0;
        start_i     = 1'b0;
        thr_i       = 8'd0;
        out_ready_i = 1'b1;
        for (int i = 0; i < 16384; i++) ram[i] = 8'd0;
        repeat (3) @(negedge clk_i);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_out_data", out_data_o, 0);
        chk("rst_out_addr", out_addr_o, 0);
        chk("rst_res_rd", res_rd_o, 0);
        chk("rst_res_addr", res_addr_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_max_dist", max_dist_o, 0);
        reset_i = 1'b1;
        @(negedge clk_i);

        // Abort with word 5 pending.
        for (int i = 0; i < 16384; i++) ram[i] = 8'(i % 7);
        start_i = 1'b1;
        thr_i   = 8'd3;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int w = 0; w < 6; w++) begin
            wait_n = 0;
            while (!out_valid_o && wait_n < 40) begin
                @(negedge clk_i);
                wait_n++;
            end
            chk("abort_addr", out_addr_o, w);
            if (w == 5) out_ready_i = 1'b0;
            else @(negedge clk_i);
        end
        repeat (2) @(negedge clk_i);
        chk("abort_hold_valid", out_valid_o, 1);
        chk("abort_hold_addr", out_addr_o, 5);
        chk("abort_hold_data", out_data_o, ref_word(5, 8'd3));
        reset_i = 1'b0;
        @(negedge clk_i);
        reset_i = 1'b1;
        chk("abort_valid", out_valid_o, 0);
        chk("abort_busy", busy_o, 0);
        chk("abort_res_rd", res_rd_o, 0);
        chk("abort_out_addr", out_addr_o, 0);
        chk("abort_out_data", out_data_o, 0);
        repeat (3) @(negedge clk_i);
        chk("abort_stays_idle", busy_o, 0);

        // All-zero map, thr=1: every word 0x0000, done at cycle 17410.
        for (int i = 0; i < 16384; i++) ram[i] = 8'd0;
        do_pass(8'd1, 1'b0, 1'b0, 1'b1, 8'd0);

        // Ramp map, thr=8, word 0 stalled for 50 cycles.
        for (int i = 0; i < 16384; i++) ram[i] = 8'(i);
        do_pass(8'd8, 1'b1, 1'b0, 1'b0, RAMP_MAX);

        // Single pixel 48 = 5, thr=5, start re-pulsed at word 100 with thr=0.
        for (int i = 0; i < 16384; i++) ram[i] = 8'd0;
        ram[48] = 8'd5;
        do_pass(8'd5, 1'b0, 1'b1, 1'b1, ONE_MAX);

        repeat (3) @(negedge clk_i);
        chk("idle_after_pass", busy_o, 0);
        chk("no_extra_done", done_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
